// File: rtl/updown_mod_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : updown_mod_counter_pkg
//  Description : Shared constants and helpers for the up/down modulo counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package updown_mod_counter_pkg;

    // Values of the up_down input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Values of the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Prescaler counter width; a single bit even when PRESCALE is 1
    function automatic int prescale_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/updown_mod_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : updown_mod_counter_if
//  Description : Control and status bundle of the up/down modulo counter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             up_down;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    // Whoever controls the counter
    modport master (
        output enable, up_down, clear, load, load_val,
        input  count, tc, ovf
    );

    // The counter itself
    modport slave (
        input  enable, up_down, clear, load, load_val,
        output count, tc, ovf
    );
endinterface
`default_nettype wire

// File: rtl/updown_mod_counter_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Emits one tick every PRESCALE enabled cycles; restart
//                returns the phase to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import updown_mod_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic enable,
    input  wire logic restart,
    output logic      tick
);

    localparam int PW = prescale_width(PRESCALE);

    generate
        if (PRESCALE == 1) begin : g_passthrough
            // Every enabled cycle is a tick; no state required
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, reset, restart};
            assign tick          = enable;
        end else begin : g_divide
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] phase_q;

            // Phase counter 0..PRESCALE-1, frozen while enable is low
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    phase_q <= '0;
                end else if (restart) begin
                    phase_q <= '0;
                end else if (enable) begin
                    phase_q <= (phase_q == LAST) ? '0 : phase_q + PW'(1);
                end
            end

            assign tick = enable && (phase_q == LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_mod_counter
//  Description : Parametrised up/down modulo counter with wrap/saturate mode,
//                prescaler, synchronous clear/load, tc pulse and sticky ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               SATURATE = MODE_WRAP,
    parameter int               PRESCALE = 1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    updown_mod_counter_if.slave bus
);

    localparam bit HOLD_AT_ENDS = (SATURATE == MODE_SAT);

    generate
        if (!(SATURATE == MODE_WRAP || SATURATE == MODE_SAT)) begin : g_bad_mode
            $error("updown_mod_counter: SATURATE must be MODE_WRAP or MODE_SAT");
        end
    endgenerate

    logic             tick;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (bus.enable),
        .restart (bus.clear | bus.load),
        .tick    (tick)
    );

    // Next state: clear beats load beats step; tc falls unless a boundary step
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (bus.clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            count_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        end else if (tick) begin
            unique case (bus.up_down)
                DIR_UP: begin
                    if (count_q >= MAX_VAL) begin
                        count_d = HOLD_AT_ENDS ? MAX_VAL : '0;
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                DIR_DOWN: begin
                    if (count_q == '0) begin
                        count_d = HOLD_AT_ENDS ? '0 : MAX_VAL;
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Count and flag registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_mod_counter
//  Description : Directed self-checking bench for updown_mod_counter, using
//                four instances with different parameter sets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;
    import updown_mod_counter_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // a: mod-10 wrap, b: mod-10 saturate, c: mod-10 wrap /3, d: mod-16 wrap
    updown_mod_counter_if #(.WIDTH(4)) if_a ();
    updown_mod_counter_if #(.WIDTH(4)) if_b ();
    updown_mod_counter_if #(.WIDTH(4)) if_c ();
    updown_mod_counter_if #(.WIDTH(4)) if_d ();

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(4'd9),  .SATURATE(MODE_WRAP), .PRESCALE(1))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    updown_mod_counter #(.WIDTH(4), .MAX_VAL(4'd9),  .SATURATE(MODE_SAT),  .PRESCALE(1))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    updown_mod_counter #(.WIDTH(4), .MAX_VAL(4'd9),  .SATURATE(MODE_WRAP), .PRESCALE(3))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));
    updown_mod_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(MODE_WRAP), .PRESCALE(1))
        dut_d (.clk(clk), .reset(reset), .bus(if_d));

    task automatic idle_all();
        {if_a.enable, if_a.up_down, if_a.clear, if_a.load, if_a.load_val} = '0;
        {if_b.enable, if_b.up_down, if_b.clear, if_b.load, if_b.load_val} = '0;
        {if_c.enable, if_c.up_down, if_c.clear, if_c.load, if_c.load_val} = '0;
        {if_d.enable, if_d.up_down, if_d.clear, if_d.load, if_d.load_val} = '0;
    endtask

    // Advance n rising edges and settle just after the last one
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_all();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        edges(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({if_a.count, if_a.tc, if_a.ovf} !== 6'b0) begin
            errors++;
            $display("FAIL reset_a: got count=%0d tc=%b ovf=%b, want 0 0 0", if_a.count, if_a.tc, if_a.ovf);
        end
        checks++;
        if ({if_b.count, if_b.tc, if_b.ovf} !== 6'b0) begin
            errors++;
            $display("FAIL reset_b: got count=%0d tc=%b ovf=%b, want 0 0 0", if_b.count, if_b.tc, if_b.ovf);
        end
        checks++;
        if ({if_c.count, if_c.tc, if_c.ovf} !== 6'b0) begin
            errors++;
            $display("FAIL reset_c: got count=%0d tc=%b ovf=%b, want 0 0 0", if_c.count, if_c.tc, if_c.ovf);
        end
        checks++;
        if ({if_d.count, if_d.tc, if_d.ovf} !== 6'b0) begin
            errors++;
            $display("FAIL reset_d: got count=%0d tc=%b ovf=%b, want 0 0 0", if_d.count, if_d.tc, if_d.ovf);
        end
    endtask

    // 0..9 then wrap to 0 with a single tc pulse, ovf sticky afterwards
    task automatic test_basic_up();
        logic [3:0] exp_count;
        logic       exp_tc;
        do_reset();
        if_a.enable  = 1'b1;
        if_a.up_down = DIR_UP;
        for (int k = 1; k <= 11; k++) begin
            edges(1);
            exp_count = (k == 10) ? 4'd0 : (k == 11) ? 4'd1 : 4'(k);
            exp_tc    = (k == 10);
            checks++;
            if (if_a.count !== exp_count || if_a.tc !== exp_tc) begin
                errors++;
                $display("FAIL basic_up step %0d: got count=%0d tc=%b, want %0d %b",
                         k, if_a.count, if_a.tc, exp_count, exp_tc);
            end
        end
        checks++;
        if (if_a.ovf !== 1'b1) begin
            errors++;
            $display("FAIL basic_up_ovf: got %b, want 1", if_a.ovf);
        end
        idle_all();
    endtask

    // Load 2, count down into 0 and hold; tc on every hold tick
    task automatic test_saturate();
        logic [3:0] exp_count [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        logic       exp_tc    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_ovf   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        if_b.load     = 1'b1;
        if_b.load_val = 4'd2;
        edges(1);
        if_b.load = 1'b0;
        checks++;
        if (if_b.count !== 4'd2) begin
            errors++;
            $display("FAIL sat_load: got count=%0d, want 2", if_b.count);
        end
        if_b.enable  = 1'b1;
        if_b.up_down = DIR_DOWN;
        for (int k = 0; k < 4; k++) begin
            edges(1);
            checks++;
            if (if_b.count !== exp_count[k] || if_b.tc !== exp_tc[k] || if_b.ovf !== exp_ovf[k]) begin
                errors++;
                $display("FAIL sat_down tick %0d: got count=%0d tc=%b ovf=%b, want %0d %b %b",
                         k, if_b.count, if_b.tc, if_b.ovf, exp_count[k], exp_tc[k], exp_ovf[k]);
            end
        end
        // Top end: load 9, an up tick holds at 9 with tc
        if_b.enable   = 1'b0;
        if_b.load     = 1'b1;
        if_b.load_val = 4'd9;
        edges(1);
        if_b.load    = 1'b0;
        if_b.enable  = 1'b1;
        if_b.up_down = DIR_UP;
        edges(1);
        checks++;
        if (if_b.count !== 4'd9 || if_b.tc !== 1'b1) begin
            errors++;
            $display("FAIL sat_up_hold: got count=%0d tc=%b, want 9 1", if_b.count, if_b.tc);
        end
        idle_all();
    endtask

    // Divide by 3 with an enable gap, then load restarts the phase
    task automatic test_prescaler();
        do_reset();
        if_c.up_down = DIR_UP;
        if_c.enable  = 1'b1;
        edges(2);
        checks++;
        if (if_c.count !== 4'd0) begin
            errors++;
            $display("FAIL presc_2: got count=%0d, want 0", if_c.count);
        end
        edges(1);
        checks++;
        if (if_c.count !== 4'd1) begin
            errors++;
            $display("FAIL presc_3: got count=%0d, want 1", if_c.count);
        end
        edges(1);                   // 4 enabled edges, phase 1
        if_c.enable = 1'b0;
        edges(4);
        checks++;
        if (if_c.count !== 4'd1) begin
            errors++;
            $display("FAIL presc_gap: got count=%0d, want 1", if_c.count);
        end
        if_c.enable = 1'b1;
        edges(5);                   // 9 enabled edges in total
        checks++;
        if (if_c.count !== 4'd3) begin
            errors++;
            $display("FAIL presc_9: got count=%0d, want 3", if_c.count);
        end
        edges(1);                   // phase now 1
        if_c.load     = 1'b1;
        if_c.load_val = 4'd5;
        edges(1);
        if_c.load = 1'b0;
        edges(2);
        checks++;
        if (if_c.count !== 4'd5) begin
            errors++;
            $display("FAIL presc_restart_hold: got count=%0d, want 5", if_c.count);
        end
        edges(1);
        checks++;
        if (if_c.count !== 4'd6) begin
            errors++;
            $display("FAIL presc_restart_tick: got count=%0d, want 6", if_c.count);
        end
        idle_all();
    endtask

    task automatic test_priority();
        do_reset();
        if_a.enable  = 1'b1;
        if_a.up_down = DIR_UP;
        edges(13);                  // wrapped once: count 3, ovf 1
        if_a.clear    = 1'b1;
        if_a.load     = 1'b1;
        if_a.load_val = 4'd5;
        edges(1);
        checks++;
        if (if_a.count !== 4'd0 || if_a.ovf !== 1'b0 || if_a.tc !== 1'b0) begin
            errors++;
            $display("FAIL prio_clear: got count=%0d tc=%b ovf=%b, want 0 0 0", if_a.count, if_a.tc, if_a.ovf);
        end
        if_a.clear    = 1'b0;
        if_a.enable   = 1'b0;
        if_a.load_val = 4'd15;
        edges(1);
        checks++;
        if (if_a.count !== 4'd9) begin
            errors++;
            $display("FAIL prio_load_clamp: got count=%0d, want 9", if_a.count);
        end
        if_a.load   = 1'b0;
        if_a.enable = 1'b1;
        edges(1);                   // 9 -> 0, sets ovf
        if_a.enable   = 1'b0;
        if_a.load     = 1'b1;
        if_a.load_val = 4'd4;
        edges(1);
        checks++;
        if (if_a.count !== 4'd4 || if_a.tc !== 1'b0 || if_a.ovf !== 1'b1) begin
            errors++;
            $display("FAIL prio_load_keeps_ovf: got count=%0d tc=%b ovf=%b, want 4 0 1",
                     if_a.count, if_a.tc, if_a.ovf);
        end
        idle_all();
    endtask

    task automatic test_async_reset();
        do_reset();
        if_a.enable  = 1'b1;
        if_a.up_down = DIR_UP;
        if_c.enable  = 1'b1;
        if_c.up_down = DIR_UP;
        edges(17);                  // a: count 7, ovf 1; c: count 5, phase 2
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (if_a.count !== 4'd0 || if_a.tc !== 1'b0 || if_a.ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d tc=%b ovf=%b, want 0 0 0", if_a.count, if_a.tc, if_a.ovf);
        end
        @(negedge clk);
        reset = 1'b1;
        edges(2);
        checks++;
        if (if_a.count !== 4'd2 || if_c.count !== 4'd0) begin
            errors++;
            $display("FAIL async_resume_2: got a=%0d c=%0d, want 2 0", if_a.count, if_c.count);
        end
        edges(1);
        checks++;
        if (if_c.count !== 4'd1) begin
            errors++;
            $display("FAIL async_resume_presc: got c=%0d, want 1", if_c.count);
        end
        idle_all();
    endtask

    task automatic test_direction_flip();
        do_reset();
        if_d.enable  = 1'b1;
        if_d.up_down = DIR_DOWN;
        edges(1);
        checks++;
        if (if_d.count !== 4'd15 || if_d.tc !== 1'b1) begin
            errors++;
            $display("FAIL flip_down: got count=%0d tc=%b, want 15 1", if_d.count, if_d.tc);
        end
        if_d.up_down = DIR_UP;
        edges(1);
        checks++;
        if (if_d.count !== 4'd0 || if_d.tc !== 1'b1) begin
            errors++;
            $display("FAIL flip_up: got count=%0d tc=%b, want 0 1", if_d.count, if_d.tc);
        end
        edges(1);
        checks++;
        if (if_d.count !== 4'd1 || if_d.tc !== 1'b0 || if_d.ovf !== 1'b1) begin
            errors++;
            $display("FAIL flip_after: got count=%0d tc=%b ovf=%b, want 1 0 1", if_d.count, if_d.tc, if_d.ovf);
        end
        idle_all();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_basic_up();
        test_saturate();
        test_prescaler();
        test_priority();
        test_async_reset();
        test_direction_flip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
